// File: rtl/switch_bounce_gen.sv
// rtl/switch_bounce_gen.sv - emulated bouncing mechanical switch for exercising debouncers
// Each accepted request drives sw_o to level_i through 1+BounceEdges edges, then settles and pulses done_o.
module switch_bounce_gen #(
  parameter int         ClkRate     = 10_000_000,
  parameter int         Baud        = 1_000_000,
  parameter int         BounceEdges = 4,
  parameter int         GapTicks    = 2,
  parameter int         RandGaps    = 0,
  parameter logic [7:0] Seed        = 8'hA5,
  parameter int         SettleTicks = 5
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic level_i,
  output logic busy_o,
  output logic done_o,
  output logic sw_o
);

  localparam int Div    = ClkRate / Baud;
  localparam int TickW  = (Div > 1) ? $clog2(Div) : 1;
  localparam int GapMax = (GapTicks > 8) ? ((GapTicks > SettleTicks) ? GapTicks : SettleTicks)
                                         : ((SettleTicks > 8) ? SettleTicks : 8);
  localparam int GapW   = $clog2(GapMax + 1);
  localparam int EdgeW  = (BounceEdges > 0) ? $clog2(BounceEdges + 1) : 1;

  localparam logic [TickW-1:0] TickLast  = TickW'(Div - 1);
  localparam logic [GapW-1:0]  GapFixed  = GapW'(GapTicks);
  localparam logic [GapW-1:0]  SettleEnd = GapW'(SettleTicks);
  localparam logic [EdgeW-1:0] EdgesInit = EdgeW'(BounceEdges);

  if (Div < 1) begin : g_err_div
    $error("switch_bounce_gen: ClkRate/Baud must be at least 1");
  end
  if ((BounceEdges % 2) != 0) begin : g_err_edges
    $error("switch_bounce_gen: BounceEdges must be even");
  end
  if (Seed == 8'h00) begin : g_err_seed
    $error("switch_bounce_gen: Seed must be nonzero");
  end
  if (SettleTicks < 1) begin : g_err_settle
    $error("switch_bounce_gen: SettleTicks must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

  state_t           state_q, state_d;
  logic             sw_q, sw_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [EdgeW-1:0] edges_q, edges_d;

  logic            tick;
  logic [GapW-1:0] gap_next;
  logic [GapW-1:0] gap_len;
  logic            lfsr_fb;

  always_comb begin
    tick     = (tick_q == TickLast);
    gap_next = gap_q + GapW'(1);
    lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    gap_len  = (RandGaps != 0) ? (GapW'(lfsr_q[2:0]) + GapW'(1)) : GapFixed;
  end

  always_comb begin
    state_d = state_q;
    sw_d    = sw_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    lfsr_d  = lfsr_q;
    tick_d  = tick_q;
    gap_d   = gap_q;
    edges_d = edges_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          busy_d = 1'b1;
          tick_d = '0;
          gap_d  = '0;
          if (level_i != sw_q) begin
            sw_d = level_i;
            if (BounceEdges == 0) begin
              state_d = SETTLE;
            end else begin
              edges_d = EdgesInit;
              state_d = BOUNCE;
            end
          end else begin
            state_d = SETTLE;
          end
        end
      end
      BOUNCE: begin
        tick_d = tick ? '0 : tick_q + TickW'(1);
        if (tick) begin
          if (gap_next == gap_len) begin
            gap_d   = '0;
            sw_d    = ~sw_q;
            lfsr_d  = {lfsr_q[6:0], lfsr_fb};
            edges_d = edges_q - EdgeW'(1);
            if (edges_q == EdgeW'(1)) state_d = SETTLE;
          end else begin
            gap_d = gap_next;
          end
        end
      end
      SETTLE: begin
        tick_d = tick ? '0 : tick_q + TickW'(1);
        if (tick) begin
          if (gap_next == SettleEnd) begin
            gap_d   = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            gap_d = gap_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sw_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lfsr_q  <= Seed;
      tick_q  <= '0;
      gap_q   <= '0;
      edges_q <= '0;
    end else begin
      state_q <= state_d;
      sw_q    <= sw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lfsr_q  <= lfsr_d;
      tick_q  <= tick_d;
      gap_q   <= gap_d;
      edges_q <= edges_d;
    end
  end

  assign sw_o   = sw_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// tb/tb_switch_bounce_gen.sv - bench for switch_bounce_gen, fixed-gap and random-gap instances
// A timeline model per instance predicts sw/busy/done every cycle.
module tb_switch_bounce_gen;

  localparam int Div = 10;
  localparam int G   = 2;
  localparam int B   = 4;
  localparam int S   = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0, level = 1'b0;
  logic req_r = 1'b0, level_r = 1'b0;
  logic busy0, done0, sw0, busy1, done1, sw1;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  switch_bounce_gen dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .level_i(level),
    .busy_o(busy0), .done_o(done0), .sw_o(sw0)
  );

  switch_bounce_gen #(.RandGaps(1), .Seed(8'hA5)) dut_r (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_r), .level_i(level_r),
    .busy_o(busy1), .done_o(done1), .sw_o(sw1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: on acceptance, the whole edge timeline (relative to acceptance) is laid out up front.
  logic       m_sw[2], m_busy[2], m_done[2];
  logic [7:0] m_lfsr[2];
  int         m_t[2], m_dt[2], m_nt[2];
  int         m_tt[2][16];

  task automatic model_step(input int i, input logic rn, input logic rq, input logic lv);
    int acc;
    int gap;
    m_done[i] = 1'b0;
    if (!rn) begin
      m_sw[i] = 1'b0; m_busy[i] = 1'b0; m_lfsr[i] = 8'hA5; m_nt[i] = 0;
    end else if (m_busy[i]) begin
      m_t[i]++;
      for (int j = 0; j < m_nt[i]; j++)
        if (m_tt[i][j] == m_t[i]) m_sw[i] = ~m_sw[i];
      if (m_t[i] == m_dt[i]) begin
        m_done[i] = 1'b1;
        m_busy[i] = 1'b0;
      end
    end else if (rq) begin
      m_busy[i] = 1'b1; m_t[i] = 0; m_nt[i] = 0; acc = 0;
      if (lv != m_sw[i]) begin
        m_sw[i] = lv;
        for (int e = 0; e < B; e++) begin
          gap = (i == 1) ? 1 + int'(m_lfsr[i][2:0]) : G;
          acc += gap * Div;
          m_tt[i][e] = acc;
          m_lfsr[i] = {m_lfsr[i][6:0], m_lfsr[i][7] ^ m_lfsr[i][5] ^ m_lfsr[i][4] ^ m_lfsr[i][3]};
        end
        m_nt[i] = B;
      end
      m_dt[i] = acc + S * Div;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rst_n, req, level);
    model_step(1, rst_n, req_r, level_r);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  int   e0[$], e1[$], d0[$], d1[$];
  logic p0 = 1'b0, p1 = 1'b0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk($sformatf("sw0@%0d", cyc), int'(sw0), int'(m_sw[0]));
      chk($sformatf("busy0@%0d", cyc), int'(busy0), int'(m_busy[0]));
      chk($sformatf("done0@%0d", cyc), int'(done0), int'(m_done[0]));
      chk($sformatf("sw1@%0d", cyc), int'(sw1), int'(m_sw[1]));
      chk($sformatf("busy1@%0d", cyc), int'(busy1), int'(m_busy[1]));
      chk($sformatf("done1@%0d", cyc), int'(done1), int'(m_done[1]));
    end
    if (sw0 !== p0) e0.push_back(cyc);
    if (sw1 !== p1) e1.push_back(cyc);
    if (done0) d0.push_back(cyc);
    if (done1) d1.push_back(cyc);
    p0 = sw0;
    p1 = sw1;
  end

  task automatic clear_logs();
    e0.delete(); e1.delete(); d0.delete(); d1.delete();
  endtask

  task automatic run_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_fixed(input string nm, input int k);
    chk({nm, " edge count"}, e0.size(), 5);
    for (int j = 0; j < e0.size() && j < 5; j++)
      chk($sformatf("%s edge%0d offset", nm, j), e0[j] - k, 20 * j);
    chk({nm, " done count"}, d0.size(), 1);
    if (d0.size() > 0) chk({nm, " done offset"}, d0[0] - k, 130);
  endtask

  int k;
  int roff[5];

  initial begin
    repeat (3) @(negedge clk);
    chk("reset sw", int'(sw0), 0);
    chk("reset busy", int'(busy0), 0);
    chk("reset done", int'(done0), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic fixed-gap rise alongside the random-gap instance
    clear_logs();
    req = 1'b1; level = 1'b1; req_r = 1'b1; level_r = 1'b1; k = cyc + 1;
    @(negedge clk);
    req = 1'b0; req_r = 1'b0; level = 1'b0; level_r = 1'b0;
    run_until(k + 260);
    check_fixed("rise", k);
    chk("rise final sw", int'(sw0), 1);
    roff[0] = 0; roff[1] = 60; roff[2] = 90; roff[3] = 150; roff[4] = 180;
    chk("rand edge count", e1.size(), 5);
    for (int j = 0; j < e1.size() && j < 5; j++)
      chk($sformatf("rand edge%0d offset", j), e1[j] - k, roff[j]);
    chk("rand done count", d1.size(), 1);
    if (d1.size() > 0) chk("rand done offset", d1[0] - k, 230);
    chk("rand final sw", int'(sw1), 1);

    // Same level: settle only
    clear_logs();
    req = 1'b1; level = 1'b1; k = cyc + 1;
    @(negedge clk);
    req = 1'b0;
    run_until(k + 80);
    chk("same edges", e0.size(), 0);
    chk("same done count", d0.size(), 1);
    if (d0.size() > 0) chk("same done offset", d0[0] - k, 50);

    // Request pulsed mid-bounce is dropped
    clear_logs();
    req = 1'b1; level = 1'b0; k = cyc + 1;
    @(negedge clk);
    req = 1'b0; level = 1'b1;
    run_until(k + 29);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    run_until(k + 160);
    check_fixed("ignore", k);
    chk("ignore final sw", int'(sw0), 0);

    // Reset mid-bounce aborts, then a fresh request behaves normally
    clear_logs();
    req = 1'b1; level = 1'b1; k = cyc + 1;
    @(negedge clk);
    req = 1'b0;
    run_until(k + 44);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort sw", int'(sw0), 0);
    chk("abort busy", int'(busy0), 0);
    run_until(k + 160);
    chk("abort done count", d0.size(), 0);
    clear_logs();
    req = 1'b1; level = 1'b1; k = cyc + 1;
    @(negedge clk);
    req = 1'b0;
    run_until(k + 140);
    check_fixed("after abort", k);

    // Random traffic, level noise and occasional resets
    for (int n = 0; n < 8000; n++) begin
      @(negedge clk);
      req     = ($urandom_range(0, 19) == 0);
      level   = 1'($urandom);
      req_r   = ($urandom_range(0, 19) == 0);
      level_r = 1'($urandom);
      rst_n   = ($urandom_range(0, 699) != 0);
    end
    rst_n = 1'b1; req = 1'b0; req_r = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
